// File: rtl/demux_4_stream.sv
// Four-way valid/ready stream demultiplexer with a 2-entry FIFO per output lane.
// Optional per-lane pop counters are built when DEMUX_COUNT_EN is defined.
module demux_4_stream #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       count0,
  output logic [7:0]       count1,
  output logic [7:0]       count2,
  output logic [7:0]       count3
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  lane_state_t      state_q [LANES];
  lane_state_t      state_d [LANES];
  logic [WIDTH-1:0] head_q  [LANES];
  logic [WIDTH-1:0] head_d  [LANES];
  logic [WIDTH-1:0] tail_q  [LANES];
  logic [WIDTH-1:0] tail_d  [LANES];

  logic [LANES-1:0] push_c;
  logic [LANES-1:0] pop_c;

  // Readiness depends only on the selected lane's registered occupancy.
  assign in_ready = (state_q[in_sel] != FULL);

  always_comb begin
    out_valid = '0;
    push_c    = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      out_valid[k] = (state_q[k] != EMPTY);
      push_c[k]    = in_valid && in_ready && (in_sel == 2'(k));
    end
  end

  assign pop_c = out_valid & out_ready;

  // Per-lane next-state and FIFO storage update.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      state_d[k] = state_q[k];
      head_d[k]  = head_q[k];
      tail_d[k]  = tail_q[k];
      case (state_q[k])
        EMPTY: begin
          if (push_c[k]) begin
            head_d[k]  = in_data;
            state_d[k] = ONE;
          end
        end
        ONE: begin
          if (push_c[k] && pop_c[k]) begin
            head_d[k] = in_data;
          end else if (push_c[k]) begin
            tail_d[k]  = in_data;
            state_d[k] = FULL;
          end else if (pop_c[k]) begin
            state_d[k] = EMPTY;
          end
        end
        FULL: begin
          if (pop_c[k]) begin
            head_d[k]  = tail_q[k];
            state_d[k] = ONE;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(LANES); k++) begin
        state_q[k] <= EMPTY;
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(LANES); k++) begin
        state_q[k] <= state_d[k];
        head_q[k]  <= head_d[k];
        tail_q[k]  <= tail_d[k];
      end
    end
  end

  assign out_data0 = head_q[0];
  assign out_data1 = head_q[1];
  assign out_data2 = head_q[2];
  assign out_data3 = head_q[3];

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q [LANES];

  // Wrapping pop-handshake counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(LANES); k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (pop_c[k]) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  assign count0 = cnt_q[0];
  assign count1 = cnt_q[1];
  assign count2 = cnt_q[2];
  assign count3 = cnt_q[3];
`else
  assign count0 = '0;
  assign count1 = '0;
  assign count2 = '0;
  assign count3 = '0;
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// Scoreboard bench for demux_4_stream: driver queues expected words per lane,
// a negedge monitor checks out_valid and every popped word against the queues.
module tb_demux_4_stream;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] count0, count1, count2, count3;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q [4][$];

`ifdef DEMUX_COUNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
`endif

  demux_4_stream #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready),
    .count0(count0), .count1(count1), .count2(count2), .count3(count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] lane_data(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // Monitor: occupancy consistency, then pop compare against scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_valid[k] !== (exp_q[k].size() != 0)) begin
          errors++;
          $display("FAIL valid lane%0d: actual %b required %b", k, out_valid[k],
                   exp_q[k].size() != 0);
        end
        if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL pop lane%0d: actual %0h required none", k, lane_data(k));
          end else begin
            if (lane_data(k) !== exp_q[k][0]) begin
              errors++;
              $display("FAIL pop lane%0d: actual %0h required %0h", k, lane_data(k), exp_q[k][0]);
            end
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic push_word(input logic [1:0] sel, input logic [3:0] data, input logic acc);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    @(negedge clk);
    check($sformatf("in_ready sel%0d", sel), 32'(in_ready), 32'(acc));
    @(posedge clk);
    if (acc) exp_q[sel].push_back(data);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1 reset_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    check("rst out_data", {16'h0, out_data3, out_data2, out_data1, out_data0}, 32'h0);
    check("rst counts", {count3, count2, count1, count0}, 32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    idle(2);
    do_reset();
    check_reset_state();

    // Single word to lane 2, popped the following edge.
    out_ready = 4'b1111;
    push_word(2'd2, 4'hA, 1'b1);
    check("t1 out_valid", 32'(out_valid), 32'h4);
    check("t1 out_data2", 32'(out_data2), 32'hA);
    idle(1);
    check("t1 drained", 32'(out_valid), 32'h0);
    check("t1 count2", 32'(count2), 32'(CNT_ONE));

    // Fill lane 0, back-pressure, then side lane, then drain in order.
    do_reset();
    out_ready = 4'b1110;
    push_word(2'd0, 4'h1, 1'b1);
    push_word(2'd0, 4'h2, 1'b1);
    push_word(2'd0, 4'h3, 1'b0);
    push_word(2'd1, 4'h4, 1'b1);
    check("t2 head0 held", 32'(out_data0), 32'h1);
    in_sel = 2'd0;
    out_ready = 4'b1111;
    idle(1);
    check("t2 in_ready back", 32'(in_ready), 32'h1);
    check("t2 head0 second", 32'(out_data0), 32'h2);
    idle(2);

    // Streaming into lane 3 while it is being drained.
    push_word(2'd3, 4'h4, 1'b1);
    push_word(2'd3, 4'h5, 1'b1);
    push_word(2'd3, 4'h6, 1'b1);
    push_word(2'd3, 4'h7, 1'b1);
    check("t3 lane3 one", 32'(out_valid), 32'h8);
    idle(2);

    // Lane 1 stalled FULL while lanes 0 and 2 stream.
    out_ready = 4'b1101;
    push_word(2'd1, 4'h8, 1'b1);
    push_word(2'd1, 4'h9, 1'b1);
    for (int i = 0; i < 6; i++)
      push_word((i % 2 == 0) ? 2'd0 : 2'd2, 4'(i + 10), 1'b1);
    push_word(2'd1, 4'hC, 1'b0);
    check("t4 head1 held", 32'(out_data1), 32'h8);
    out_ready = 4'b1111;
    idle(3);

    // Reset with lanes 0 and 3 full and a word in flight.
    out_ready = 4'b0000;
    push_word(2'd0, 4'h1, 1'b1);
    push_word(2'd0, 4'h2, 1'b1);
    push_word(2'd3, 4'h3, 1'b1);
    push_word(2'd3, 4'h4, 1'b1);
    in_sel   = 2'd2;
    in_data  = 4'hF;
    in_valid = 1'b1;
    do_reset();
    check_reset_state();
    out_ready = 4'b1111;
    idle(3);

    // 257 pops on lane 1 wrap the counter to 1.
    do_reset();
    for (int i = 0; i < 257; i++) push_word(2'd1, 4'(i), 1'b1);
    idle(2);
    check("t6 count1 wrap", 32'(count1), 32'(CNT_ONE));

    for (int k = 0; k < 4; k++)
      check($sformatf("drained lane%0d", k), 32'(exp_q[k].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_4_stream.md
# demux_4_stream

Four-way stream demultiplexer: routes each word from one valid/ready input stream to one of four valid/ready output streams, chosen by a 2-bit select carried with the word. Each output lane has a 2-entry FIFO, so a stalled lane does not block words bound for other lanes. It is the distribution-side counterpart of the 4:1 select path and sits wherever one producer feeds four independent consumers.

## Interface
- WIDTH, 4, data word width in bits
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- in_data  input  WIDTH  input word
- in_sel  input  2  destination lane for in_data (0..3)
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block accepts the word this cycle
- out_data0..out_data3  output  WIDTH each  head word of lane FIFO 0..3
- out_valid  output  4  bit k: lane k FIFO non-empty
- out_ready  input  4  bit k: consumer k accepts out_data k
- count0..count3  output  8 each  handshake counters per lane (Configuration)

## Operation
- Input handshake: a word is accepted on a rising edge when in_valid && in_ready. in_data and in_sel are sampled only then.
- in_ready = (lane FIFO in_sel holds < 2 entries). It depends only on in_sel and registered occupancy. There is no combinational path from out_ready to in_ready.
- in_ready may be high while in_valid is low. The producer may change in_sel freely while in_valid is low.
- Each lane FIFO is 2 entries, first in first out, with an occupancy of 0, 1 or 2.
- Lane state: EMPTY (0), ONE (1), FULL (2).
  - EMPTY to ONE on push.
  - ONE to FULL on push without pop.
  - ONE to EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop. The popped word is the old head, and the pushed word becomes the new head.
  - FULL to ONE on pop. A push cannot occur in FULL.
- Output handshake on lane k: a pop occurs when out_valid[k] && out_ready[k].
  - out_valid[k] = occupancy k != 0.
  - out_data k = head entry. It is held stable while out_valid[k] && !out_ready[k].
- Lanes are fully independent. Pops on any subset of lanes and a push to any one lane may all happen in the same cycle.
- Order is preserved within a lane. No ordering is defined across lanes.
- Reset (reset_n low at a rising edge) has priority over every handshake in that cycle:
  - all occupancies become 0 and FIFO contents are discarded;
  - an in-flight input word in that cycle is dropped;
  - outputs after the edge: out_valid = 4'b0000, in_ready = 1, out_data0..3 = 0, count0..3 = 0.
- Reset mid-operation discards queued words. No pop handshake completes on the reset edge.

## Timing
- Latency is 1 cycle. A word accepted at edge N is visible on out_data k, with out_valid[k] = 1, after edge N. The earliest it can pop is at edge N+1.
- Throughput to one lane is 1 word/cycle when the consumer holds out_ready high. The lane stays in ONE with a push and a pop every cycle.
- A lane in FULL deasserts in_ready for words selecting it. in_ready reasserts in the cycle after the pop edge.
- All outputs are registered or derived from registers plus in_sel only.

## Configuration
- DEMUX_COUNT_EN defined:
  - count k increments by 1 on every lane-k pop handshake;
  - the counter is 8 bits and wraps from 255 to 0;
  - it is cleared by reset.
- DEMUX_COUNT_EN undefined:
  - count0..count3 ports remain present and are tied to 0;
  - no counter registers are built.

## Test plan
- Reset, then push lane 2 with data 4'hA while out_ready = 4'b1111. Required: out_valid = 4'b0100 and out_data2 = 4'hA one cycle later; popped on the following edge; count2 = 1 when DEMUX_COUNT_EN is defined.
- Fill lane 0 with out_ready[0] = 0 by pushing 4'h1, 4'h2, then 4'h3. Required: in_ready drops with in_sel = 0 after the second push, and the third word is not accepted. With in_sel = 1, in_ready is high and the word is accepted. Raising out_ready[0] pops 1 then 2 in order.
- Lane 3 in ONE, streaming pushes 4'h5, 4'h6, 4'h7 on consecutive cycles with out_ready[3] = 1. Required: one word popped per cycle, occupancy stays 1, no in_ready drop.
- Stall lane 1 (FULL) while streaming alternately to lanes 0 and 2. Required: lanes 0 and 2 receive every word in order, and lane 1 contents are unchanged.
- Assert reset_n = 0 with lanes 0 and 3 FULL and in_valid = 1. Required: after the edge, out_valid = 0, in_ready = 1, and counters = 0; the dropped word never appears.
- With DEMUX_COUNT_EN defined, 257 pops on lane 1. Required: count1 = 1 (wrapped). With DEMUX_COUNT_EN undefined, count1 = 0 throughout.
